// File: rtl/imm_decode_stage.sv
// Immediate-generation stage: decodes a 32-bit instruction into a sign-extended
// XLEN immediate behind a 2-entry skid buffer. Define IMM_GEN_ZICSR_EN to decode CSR zimm (fmt 5).
module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ir,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [31:0]      out_ir,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] ill_cnt
);

   if (XLEN != 32 && XLEN != 64) begin : g_badXlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
   end

   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_S    = 3'd1;
   localparam logic [2:0] FMT_B    = 3'd2;
   localparam logic [2:0] FMT_U    = 3'd3;
   localparam logic [2:0] FMT_J    = 3'd4;
   localparam logic [2:0] FMT_Z    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
      logic [31:0]      ir;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, ir: '0, tag: '0};

   state_t           state_q, state_d;
   logic             inReady_q, inReady_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic [CNT_W-1:0] illCnt_q, illCnt_d;

   logic [31:0]      iImm, sImm, bImm, uImm, jImm, zImm, imm32;
   logic [2:0]       decFmt;
   logic             decIllegal;
   entry_t           decEntry;
   logic             inHs, outHs;

   // Every format is first built as a 32-bit value whose bit 31 is the sign,
   // so one signed cast covers both XLEN widths.
   assign iImm = {{20{in_ir[31]}}, in_ir[31:20]};
   assign sImm = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
   assign bImm = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
   assign uImm = {in_ir[31:12], 12'b0};
   assign jImm = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
   assign zImm = {27'b0, in_ir[19:15]};

   always_comb begin
      imm32      = '0;
      decFmt     = FMT_NONE;
      decIllegal = 1'b0;
      case (in_ir[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
            decFmt = FMT_I;
            imm32  = iImm;
         end
         7'b0100011: begin decFmt = FMT_S; imm32 = sImm; end
         7'b1100011: begin decFmt = FMT_B; imm32 = bImm; end
         7'b0110111, 7'b0010111: begin decFmt = FMT_U; imm32 = uImm; end
         7'b1101111: begin decFmt = FMT_J; imm32 = jImm; end
         7'b0110011: decFmt = FMT_NONE;
         7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
            if (in_ir[14]) begin
               decFmt = FMT_Z;
               imm32  = zImm;
            end else begin
               decFmt = FMT_I;
               imm32  = iImm;
            end
`else
            decFmt = FMT_I;
            imm32  = iImm;
`endif
         end
         // Every recognised opcode ends in 2'b11, so this also catches compressed encodings.
         default: decIllegal = 1'b1;
      endcase
   end

   assign decEntry = '{imm: XLEN'($signed(imm32)), fmt: decFmt, illegal: decIllegal,
                       ir: in_ir, tag: in_tag};

   assign out_valid = (state_q != EMPTY);
   assign inHs      = in_valid && inReady_q;
   assign outHs     = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      illCnt_d = illCnt_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         if (inHs && decIllegal && (illCnt_q != '1)) begin
            illCnt_d = illCnt_q + CNT_W'(1);
         end
         case (state_q)
            EMPTY: begin
               if (inHs) begin
                  state_d = ONE;
                  main_d  = decEntry;
               end
            end
            ONE: begin
               if (inHs && outHs) begin
                  main_d = decEntry;
               end else if (inHs) begin
                  state_d = TWO;
                  skid_d  = decEntry;
               end else if (outHs) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (outHs) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      inReady_d = (state_d != TWO);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= EMPTY;
         inReady_q <= 1'b1;
         main_q    <= RESET_ENTRY;
         skid_q    <= RESET_ENTRY;
         illCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         inReady_q <= inReady_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         illCnt_q  <= illCnt_d;
      end
   end

   assign in_ready    = inReady_q;
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;
   assign out_ir      = main_q.ir;
   assign out_tag     = main_q.tag;
   assign ill_cnt     = illCnt_q;

endmodule
